// File: rtl/uart_tx_frame_if.sv
// Byte-in / serial-out bundle for the UART transmitter.
// master = byte source, slave = transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid,
    output par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid,
    input  par_en, par_typ,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start, LSB-first data, optional parity, stop.
// One bit per CLK; tx_out and busy come straight from flops.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic CLK,
  input  logic RST,
  uart_tx_frame_if.slave bus
);
  localparam int CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  accept;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // tx_d is the bit that goes on the line during state_d.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        accept = bus.data_valid;
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      DATA: begin
        if (cnt_q == LAST) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        accept  = bus.data_valid;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (accept) begin
      state_d   = START;
      shift_d   = bus.p_data;
      par_en_d  = bus.par_en;
      par_bit_d = (^bus.p_data) ^ bus.par_typ;
      tx_d      = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed table,
// corner sequences and random frames against a list model.
module tb_uart_tx_frame;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  d;
    bit          pe;
    bit          pt;
    int          len;
    logic [10:0] seq;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Frame as a list of line levels, one entry per bit time.
  task automatic model(input logic [7:0] d, input bit pe,
                       input bit pt, output bit f [0:10],
                       output int len);
    int n;
    n = 0;
    f[n++] = 1'b0;
    for (int i = 0; i < 8; i++) f[n++] = bit'((d >> i) % 2);
    if (pe) f[n++] = bit'(($countones(d) + int'(pt)) % 2);
    f[n++] = 1'b1;
    for (int i = n; i < 11; i++) f[i] = 1'b1;
    len = n;
  endtask

  task automatic run_frame(input string nm, input logic [7:0] d,
                           input bit pe, input bit pt,
                           input bit f [0:10], input int len,
                           input bit disturb);
    @(negedge CLK);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.data_valid = 1'b1;
    @(posedge CLK);
    #1 bus.data_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      chk($sformatf("%s tx[%0d]", nm, i), 32'(bus.tx_out), 32'(f[i]));
      chk($sformatf("%s busy[%0d]", nm, i), 32'(bus.busy), 32'd1);
      if (disturb && i == 2) begin
        bus.p_data  = ~d;
        bus.par_en  = ~pe;
        bus.par_typ = ~pt;
      end
      if (disturb && i == 3) bus.data_valid = 1'b1;
      if (disturb && i == 4) bus.data_valid = 1'b0;
    end
    @(negedge CLK);
    chk({nm, " idle tx"}, 32'(bus.tx_out), 32'd1);
    chk({nm, " idle busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit f [0:10];
    bit g [0:10];
    int len, len2;

    vt[0] = '{8'hA5, 1'b0, 1'b0, 10, 11'b0101001011};
    vt[1] = '{8'hA5, 1'b1, 1'b0, 11, 11'b01010010101};
    vt[2] = '{8'h00, 1'b1, 1'b1, 11, 11'b00000000011};
    vt[3] = '{8'h0F, 1'b0, 1'b0, 10, 11'b0111100001};
    vt[4] = '{8'hA5, 1'b1, 1'b1, 11, 11'b01010010111};
    vt[5] = '{8'h80, 1'b1, 1'b0, 11, 11'b00000000111};
    vt[6] = '{8'hFF, 1'b0, 1'b0, 10, 11'b0111111111};

    bus.p_data     = 8'hFF;
    bus.data_valid = 1'b1;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset tx", 32'(bus.tx_out), 32'd1);
    chk("reset busy", 32'(bus.busy), 32'd0);
    bus.data_valid = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk($sformatf("idle tx[%0d]", i), 32'(bus.tx_out), 32'd1);
      chk($sformatf("idle busy[%0d]", i), 32'(bus.busy), 32'd0);
    end

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 11; i++)
        f[i] = (i < vt[v].len) ? vt[v].seq[vt[v].len - 1 - i] : 1'b1;
      run_frame($sformatf("vec%0d", v), vt[v].d, vt[v].pe,
                vt[v].pt, f, vt[v].len, v[0]);
    end

    model(8'h3C, 1'b0, 1'b0, f, len);
    model(8'hC3, 1'b0, 1'b0, g, len2);
    @(negedge CLK);
    bus.p_data     = 8'h3C;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.data_valid = 1'b1;
    @(posedge CLK);
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      chk($sformatf("b2b1 tx[%0d]", i), 32'(bus.tx_out), 32'(f[i]));
      chk($sformatf("b2b1 busy[%0d]", i), 32'(bus.busy), 32'd1);
      if (i == len - 1) bus.p_data = 8'hC3;
    end
    for (int i = 0; i < len2; i++) begin
      @(negedge CLK);
      chk($sformatf("b2b2 tx[%0d]", i), 32'(bus.tx_out), 32'(g[i]));
      chk($sformatf("b2b2 busy[%0d]", i), 32'(bus.busy), 32'd1);
      if (i == 0) bus.data_valid = 1'b0;
    end
    @(negedge CLK);
    chk("b2b idle tx", 32'(bus.tx_out), 32'd1);
    chk("b2b idle busy", 32'(bus.busy), 32'd0);

    @(negedge CLK);
    bus.p_data     = 8'h55;
    bus.par_en     = 1'b0;
    bus.data_valid = 1'b1;
    @(posedge CLK);
    #1 bus.data_valid = 1'b0;
    repeat (5) @(negedge CLK);
    chk("rstmid pre tx", 32'(bus.tx_out), 32'd0);
    chk("rstmid pre busy", 32'(bus.busy), 32'd1);
    RST = 1'b0;
    #1;
    chk("rstmid tx", 32'(bus.tx_out), 32'd1);
    chk("rstmid busy", 32'(bus.busy), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("rstmid after tx", 32'(bus.tx_out), 32'd1);
      chk("rstmid after busy", 32'(bus.busy), 32'd0);
    end
    for (int i = 0; i < 11; i++)
      f[i] = (i < vt[3].len) ? vt[3].seq[vt[3].len - 1 - i] : 1'b1;
    run_frame("post-rst 0x0F", 8'h0F, 1'b0, 1'b0, f, 10, 1'b0);

    for (int r = 0; r < 40; r++) begin
      logic [7:0] d;
      bit pe, pt, dis;
      d   = 8'($urandom_range(0, 255));
      pe  = bit'($urandom_range(0, 1));
      pt  = bit'($urandom_range(0, 1));
      dis = bit'($urandom_range(0, 1));
      model(d, pe, pt, f, len);
      run_frame($sformatf("rnd%0d d=%02h pe=%0d pt=%0d", r, d, pe, pt),
                d, pe, pt, f, len, dis);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter for the final system. Serializes one parallel byte into a frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, and one stop bit.
- CLK is the TX bit clock: one serial bit per CLK cycle, so there is no oversampling.
- Counterpart of the RX chain. Its output frames must pass that chain's start, parity and stop checks.

Parameters:
- DATA_WIDTH, 8, width of the parallel data word and number of serial data bits per frame.

Ports:
- CLK  input  1  TX bit clock, rising-edge active.
- RST  input  1  asynchronous, active-low reset.
- p_data  input  DATA_WIDTH  parallel word to transmit. Sampled only on the accept edge.
- data_valid  input  1  request to send p_data.
- par_en  input  1  1 = append a parity bit. Sampled on the accept edge.
- par_typ  input  1  0 = even parity, 1 = odd parity. Sampled on the accept edge.
- tx_out  output  1  serial line, registered. Idle level is 1.
- busy  output  1  registered. High while a frame is in progress.

Behaviour:
- Reset (RST low, asynchronous):
  - FSM goes to IDLE.
  - tx_out = 1, busy = 0.
  - Shift register, bit counter and latched config all clear to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP. Each non-IDLE state drives tx_out for exactly one CLK cycle per bit.
- Accept edge: a rising CLK edge where data_valid = 1 and the FSM is in IDLE, or in STOP (back-to-back case). On that edge:
  - p_data goes into the shift register.
  - par_en and par_typ are latched.
  - Parity is computed and latched: XOR-reduce(p_data) XOR par_typ.
  - FSM moves to START.
- IDLE: tx_out = 1, busy = 0. Stay in IDLE while data_valid = 0.
- START: tx_out = 0 for one cycle. busy = 1 from the accept edge onward. Next state is DATA, with the bit counter = 0.
- DATA:
  - tx_out = shift register bit 0; shift right once per cycle.
  - Counter runs 0 .. DATA_WIDTH-1.
  - After the bit with counter = DATA_WIDTH-1: go to PARITY if latched par_en = 1, else to STOP.
- PARITY: tx_out = latched parity bit for one cycle, then go to STOP.
- STOP: tx_out = 1 for one cycle.
  - If data_valid = 1 on the closing edge: this is an accept edge. Go directly to START, busy stays 1, and there are no idle cycles between frames.
  - Otherwise go to IDLE; busy falls to 0 on that edge.
- Latency: the start bit appears on tx_out in the cycle immediately after the accept edge.
- Frame length: 2 + DATA_WIDTH + par_en cycles, i.e. 10 or 11 for the default.
- data_valid while busy (START, DATA, PARITY): ignored, and the request is not queued. The source must hold or re-assert it.
- Changes to p_data, par_en or par_typ mid-frame: no effect on the current frame.
- tx_out and busy are driven from registers only, with no combinational path from inputs to outputs.
- Reset mid-frame: the frame aborts immediately. tx_out goes to 1 asynchronously and busy to 0. The truncated frame is not resumed after reset release.

Test Plan:
- Reset/idle: hold RST low with data_valid = 1 and p_data = 0xFF -> tx_out = 1, busy = 0. Release RST with data_valid = 0 for 20 cycles -> tx_out stays 1, busy stays 0.
- No parity: p_data = 0xA5, par_en = 0, data_valid pulsed for one cycle -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 (10 cycles). busy is high for exactly 10 cycles, then tx_out = 1 idle.
- Even parity: p_data = 0xA5, par_en = 1, par_typ = 0 -> sequence 0,1,0,1,0,0,1,0,1,0,1 (parity 0, 11 cycles).
- Odd parity: p_data = 0x00, par_en = 1, par_typ = 1 -> sequence 0, eight 0s, 1, 1 (parity 1).
- Back-to-back and ignored request:
  - data_valid held high with p_data = 0x3C, then p_data = 0xC3 presented during the first frame's stop cycle (par_en = 0). Required: the second start bit immediately follows the first stop bit, busy never drops, and the second frame carries 0xC3.
  - p_data changed mid-frame: no effect on the current frame.
- Reset mid-frame: assert RST during the 4th data bit of 0x55 -> tx_out = 1 and busy = 0 immediately. After release, a new request for 0x0F produces a clean frame 0,1,1,1,1,0,0,0,0,1.
